// File: rtl/uart_tx_peripheral_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions, FSM encoding and the status packing helper.
package uart_tx_peripheral_pkg;

  localparam logic [31:0] DATA_OFFSET   = 32'h0000_0000;
  localparam logic [31:0] STATUS_OFFSET = 32'h0000_0004;

  localparam int STATUS_BUSY_BIT     = 0;
  localparam int STATUS_FULL_BIT     = 1;
  localparam int STATUS_EMPTY_BIT    = 2;
  localparam int STATUS_OVERFLOW_BIT = 3;
  localparam int STATUS_COUNT_LSB    = 4;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // Observable snapshot of the block; STATUS is packed straight from it.
  typedef struct packed {
    tx_state_e  state;
    logic       full;
    logic       empty;
    logic       overflow;
    logic [3:0] count;
  } tx_debug_t;

  function automatic logic [31:0] pack_status(input tx_debug_t d);
    logic [31:0] s;
    s = '0;
    s[STATUS_BUSY_BIT]          = (d.state != TX_IDLE);
    s[STATUS_FULL_BIT]          = d.full;
    s[STATUS_EMPTY_BIT]         = d.empty;
    s[STATUS_OVERFLOW_BIT]      = d.overflow;
    s[STATUS_COUNT_LSB +: 4]    = d.count;
    return s;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the transmitter; power-of-two depth so the pointers wrap
// naturally. Push and pop may occur on the same edge.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_peripheral.sv
// Memory-mapped UART transmitter: DATA/STATUS registers on the MEM-stage bus,
// a byte FIFO and an 8N1 serialiser running from the CPU clock.
module uart_tx_peripheral
  import uart_tx_peripheral_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int          CLKS_PER_BIT = 234,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic        mem_write,
  input  logic        mem_read,
  output logic [31:0] read_data,
  output logic        uart_tx
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  logic             sel_data;
  logic             sel_status;
  logic             data_wr;
  logic             status_wr;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_dout;
  logic [CNT_W-1:0] fifo_count;
  logic [3:0]       count4;
  logic             overflow;
  logic             unused_write_bits;

  tx_state_e         state, state_next;
  logic [BAUD_W-1:0] baud_cnt, baud_next;
  logic [2:0]        bit_idx, bit_idx_next;
  logic [7:0]        shift_reg, shift_next;
  logic              tx_next;
  tx_debug_t         debug;

  assign sel_data   = (address == BASE_ADDR + DATA_OFFSET);
  assign sel_status = (address == BASE_ADDR + STATUS_OFFSET);
  assign data_wr    = mem_write && sel_data;
  assign status_wr  = mem_write && sel_status;
  assign push       = data_wr && !fifo_full;
  assign unused_write_bits = ^write_data[31:8];

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (write_data[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Overflow is sticky: only an explicit STATUS write with bit 3 set clears it.
  always_ff @(posedge clock) begin
    if (reset)                                         overflow <= 1'b0;
    else if (data_wr && fifo_full)                     overflow <= 1'b1;
    else if (status_wr && write_data[STATUS_OVERFLOW_BIT]) overflow <= 1'b0;
  end

  generate
    if (CNT_W >= 4) begin : g_cnt_trunc
      assign count4 = fifo_count[3:0];
    end else begin : g_cnt_ext
      assign count4 = {{(4 - CNT_W){1'b0}}, fifo_count};
    end
  endgenerate

  assign debug = '{state: state, full: fifo_full, empty: fifo_empty,
                   overflow: overflow, count: count4};

  // Reads see only registered state, so a same-cycle write is not yet visible.
  always_comb begin
    read_data = '0;
    if (mem_read && sel_status) read_data = pack_status(debug);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= TX_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      uart_tx   <= 1'b1;
    end else begin
      state     <= state_next;
      baud_cnt  <= baud_next;
      bit_idx   <= bit_idx_next;
      shift_reg <= shift_next;
      uart_tx   <= tx_next;
    end
  end

  always_comb begin
    state_next   = state;
    baud_next    = baud_cnt;
    bit_idx_next = bit_idx;
    shift_next   = shift_reg;
    tx_next      = uart_tx;
    pop          = 1'b0;
    case (state)
      TX_IDLE: begin
        tx_next = 1'b1;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = fifo_dout;
          baud_next  = '0;
          tx_next    = 1'b0;
          state_next = TX_START;
        end
      end
      TX_START: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_next    = '0;
          bit_idx_next = '0;
          tx_next      = shift_reg[0];
          state_next   = TX_DATA;
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      TX_DATA: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_next = '0;
          if (bit_idx == 3'd7) begin
            tx_next    = 1'b1;
            state_next = TX_STOP;
          end else begin
            // Shift right so the next bit to send is always at [0].
            bit_idx_next = bit_idx + 3'd1;
            shift_next   = {1'b0, shift_reg[7:1]};
            tx_next      = shift_reg[1];
          end
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      TX_STOP: begin
        tx_next = 1'b1;
        if (baud_cnt == BAUD_LAST) begin
          baud_next  = '0;
          state_next = TX_IDLE;
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      default: state_next = TX_IDLE;
    endcase
  end

endmodule
